// File: rtl/regfile_scoreboard_if.sv
// +--------------------------------------------------------------------------+
// | regfile_scoreboard_if                                                    |
// | Decode / writeback / issue signal bundle for the register file with      |
// | pending-write scoreboard.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_scoreboard_if #(
  parameter int XLEN = 32
);
  // Decode read ports
  logic [4:0]      rs1_addr_i;
  logic [4:0]      rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  // Writeback write port
  logic            rf_rw_en_i;
  logic [4:0]      rd_addr_i;
  logic [XLEN-1:0] wb_data_i;
  // Issue / scoreboard control
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic            issue_long_i;
  logic            flush_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            rd_busy_o;

  // Register file side
  modport slave (
    input  rs1_addr_i, rs2_addr_i, rf_rw_en_i, rd_addr_i, wb_data_i,
           issue_valid_i, issue_rd_i, issue_long_i, flush_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, rd_busy_o
  );

  // Pipeline (decode + writeback) side
  modport master (
    output rs1_addr_i, rs2_addr_i, rf_rw_en_i, rd_addr_i, wb_data_i,
           issue_valid_i, issue_rd_i, issue_long_i, flush_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, rd_busy_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +--------------------------------------------------------------------------+
// | regfile_scoreboard                                                       |
// | Integer register file with write-through bypass on both read ports and   |
// | a pending-write scoreboard for long-latency destinations.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_scoreboard_if.slave  bus
);

  // Architectural view of the array; entry 0 is a constant, never a flop.
  logic [XLEN-1:0] rf_view [NREG];
  logic            wr_en;
  logic            set_en;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            rd_hit;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] pending_q;

  // Writes to x0 are dropped, so they neither store nor clear anything.
  assign wr_en  = bus.rf_rw_en_i && (bus.rd_addr_i != 5'd0);
  assign set_en = bus.issue_valid_i && bus.issue_long_i && (bus.issue_rd_i != 5'd0);

  assign rf_view[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NREG; i++) begin : g_reg
      logic [XLEN-1:0] reg_d;
      logic [XLEN-1:0] reg_q;

      // Load the writeback data when this entry is addressed, else hold.
      always_comb begin
        reg_d = reg_q;
        if (wr_en && (bus.rd_addr_i == 5'(i))) begin
          reg_d = bus.wb_data_i;
        end
      end

      // Register storage, cleared by reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rf_view[i] = reg_q;
    end
  endgenerate

  // Scoreboard update: clear on writeback, then set on long issue (newer
  // producer wins), then flush overrides everything.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[bus.rd_addr_i] = 1'b0;
    end
    if (set_en) begin
      pending_d[bus.issue_rd_i] = 1'b1;
    end
    if (bus.flush_i) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  // Pending-bit register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A same-cycle writeback to an address both bypasses data and hides busy.
  // wr_en already excludes x0, so a hit implies a nonzero address.
  assign rs1_hit = wr_en && (bus.rd_addr_i == bus.rs1_addr_i);
  assign rs2_hit = wr_en && (bus.rd_addr_i == bus.rs2_addr_i);
  assign rd_hit  = wr_en && (bus.rd_addr_i == bus.issue_rd_i);

  // Bypassed combinational read ports.
  always_comb begin
    bus.rs1_data_o = rf_view[bus.rs1_addr_i];
    bus.rs2_data_o = rf_view[bus.rs2_addr_i];
    if (rs1_hit) begin
      bus.rs1_data_o = bus.wb_data_i;
    end
    if (rs2_hit) begin
      bus.rs2_data_o = bus.wb_data_i;
    end
    if (bus.rs1_addr_i == 5'd0) begin
      bus.rs1_data_o = '0;
    end
    if (bus.rs2_addr_i == 5'd0) begin
      bus.rs2_data_o = '0;
    end
  end

  // Busy flags: pending and not being retired this very cycle.
  always_comb begin
    bus.rs1_busy_o = pending_q[bus.rs1_addr_i] && !rs1_hit && (bus.rs1_addr_i != 5'd0);
    bus.rs2_busy_o = pending_q[bus.rs2_addr_i] && !rs2_hit && (bus.rs2_addr_i != 5'd0);
    bus.rd_busy_o  = pending_q[bus.issue_rd_i] && !rd_hit  && (bus.issue_rd_i != 5'd0);
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_scoreboard                                                    |
// | Directed stimulus with an expectation queue and a negedge monitor.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_scoreboard;

  logic clk;
  logic rst_ni;

  regfile_scoreboard_if #(.XLEN(32)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        bd;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb1, input logic eb2, input logic ebd);
    exp_t e;
    e.name = nm; e.d1 = e1; e.d2 = e2; e.b1 = eb1; e.b2 = eb2; e.bd = ebd;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic iv, input logic il, input logic [4:0] ird,
                       input logic fl);
    bus.rs1_addr_i    = r1;
    bus.rs2_addr_i    = r2;
    bus.rf_rw_en_i    = we;
    bus.rd_addr_i     = rd;
    bus.wb_data_i     = wd;
    bus.issue_valid_i = iv;
    bus.issue_long_i  = il;
    bus.issue_rd_i    = ird;
    bus.flush_i       = fl;
  endtask

  // One cycle: drive after the edge, record what the outputs must show.
  task automatic step(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                      input logic we, input logic [4:0] rd, input logic [31:0] wd,
                      input logic iv, input logic il, input logic [4:0] ird,
                      input logic fl,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb1, input logic eb2, input logic ebd);
    @(posedge clk);
    #1;
    drive(r1, r2, we, rd, wd, iv, il, ird, fl);
    push(nm, e1, e2, eb1, eb2, ebd);
  endtask

  // Monitor: outputs are combinational and always presented; sample mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.rs1_data_o, bus.rs2_data_o, bus.rs1_busy_o, bus.rs2_busy_o, bus.rd_busy_o}
          !== {e.d1, e.d2, e.b1, e.b2, e.bd}) begin
        n_fail++;
        $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b bd=%b, want d1=%h d2=%h b1=%b b2=%b bd=%b",
                 e.name, bus.rs1_data_o, bus.rs2_data_o, bus.rs1_busy_o, bus.rs2_busy_o,
                 bus.rd_busy_o, e.d1, e.d2, e.b1, e.b2, e.bd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Every address reads zero and nothing is busy after reset.
    for (int a = 0; a < 32; a++) begin
      step("rst_read", 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(a), 1'b0,
           32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    // Write-through bypass, then array read.
    step("wr_bypass", 5'd5, 5'd6, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 0,
         32'hDEADBEEF, 32'h0, 0, 0, 0);
    step("wr_array",  5'd5, 5'd5, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0,
         32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);

    // x0 ignores writes and long issue.
    step("x0_write",  5'd0, 5'd0, 1, 5'd0, 32'h1234, 1, 1, 5'd0, 0,
         32'h0, 32'h0, 0, 0, 0);
    step("x0_after",  5'd0, 5'd5, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0,
         32'h0, 32'hDEADBEEF, 0, 0, 0);

    // Long issue to x7, busy until writeback, masked in the writeback cycle.
    step("iss7",      5'd0, 5'd7, 0, 5'd0, 32'h0, 1, 1, 5'd7, 0,
         32'h0, 32'h0, 0, 0, 0);
    step("busy7_a",   5'd7, 5'd7, 0, 5'd0, 32'h0, 0, 0, 5'd7, 0,
         32'h0, 32'h0, 1, 1, 1);
    step("busy7_b",   5'd0, 5'd7, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0,
         32'h0, 32'h0, 0, 1, 0);
    step("wb7",       5'd7, 5'd7, 1, 5'd7, 32'h55, 0, 0, 5'd7, 0,
         32'h55, 32'h55, 0, 0, 0);
    step("clr7",      5'd7, 5'd7, 0, 5'd0, 32'h0, 0, 0, 5'd7, 0,
         32'h55, 32'h55, 0, 0, 0);

    // Writeback and new long issue to x9 in one cycle: set wins.
    step("iss9",      5'd9, 5'd0, 0, 5'd0, 32'h0, 1, 1, 5'd9, 0,
         32'h0, 32'h0, 0, 0, 0);
    step("wb9_set9",  5'd9, 5'd9, 1, 5'd9, 32'h99, 1, 1, 5'd9, 0,
         32'h99, 32'h99, 0, 0, 0);
    step("set_wins",  5'd9, 5'd0, 0, 5'd0, 32'h0, 0, 0, 5'd9, 0,
         32'h99, 32'h0, 1, 0, 1);
    step("wb9_b",     5'd9, 5'd0, 1, 5'd9, 32'hA1, 0, 0, 5'd0, 0,
         32'hA1, 32'h0, 0, 0, 0);
    step("clr9",      5'd9, 5'd9, 0, 5'd0, 32'h0, 0, 0, 5'd9, 0,
         32'hA1, 32'hA1, 0, 0, 0);

    // Flush clears x3/x4, overrides a same-cycle set of x12, keeps the write.
    step("iss3",      5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 1, 5'd3, 0,
         32'h0, 32'h0, 0, 0, 0);
    step("iss4",      5'd3, 5'd0, 0, 5'd0, 32'h0, 1, 1, 5'd4, 0,
         32'h0, 32'h0, 1, 0, 0);
    step("flush",     5'd3, 5'd4, 1, 5'd3, 32'h33, 1, 1, 5'd12, 1,
         32'h33, 32'h0, 0, 1, 0);
    step("post_flush", 5'd3, 5'd4, 0, 5'd0, 32'h0, 0, 0, 5'd12, 0,
         32'h33, 32'h0, 0, 0, 0);

    // Short-latency issue never marks pending.
    step("short13",   5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 0, 5'd13, 0,
         32'h0, 32'h0, 0, 0, 0);
    step("short13_b", 5'd13, 5'd0, 0, 5'd0, 32'h0, 0, 0, 5'd13, 0,
         32'h0, 32'h0, 0, 0, 0);

    // Bypass on port 2 while port 1 reads the array.
    step("bypass2",   5'd5, 5'd20, 1, 5'd20, 32'hCAFEF00D, 0, 0, 5'd0, 0,
         32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 0);

    // Populate x10 and a pending x11, then reset mid-stream.
    step("x10_wr",    5'd20, 5'd0, 1, 5'd10, 32'hFF, 1, 1, 5'd11, 0,
         32'hCAFEF00D, 32'h0, 0, 0, 0);
    step("x10_rd",    5'd10, 5'd11, 0, 5'd0, 32'h0, 0, 0, 5'd11, 0,
         32'hFF, 32'h0, 0, 1, 1);

    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    drive(5'd10, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd11, 1'b0);
    push("rst_async", 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(5'd10, 5'd11, 1'b1, 5'd10, 32'h77, 1'b0, 1'b0, 5'd11, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drive(5'd10, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd11, 1'b0);
    push("rst_after", 32'h0, 32'h0, 0, 0, 0);
    step("rst_after2", 5'd10, 5'd20, 0, 5'd0, 32'h0, 0, 0, 5'd0, 0,
         32'h0, 32'h0, 0, 0, 0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file with a pending-write scoreboard, sitting at the receiving end of the writeback stage's register-write interface. It accepts the write-enable/data/address triple driven by writeback, supplies decode with two bypassed read ports, and tracks destination registers of issued long-latency instructions (loads, divides). This lets decode stall on RAW/WAW hazards until the matching writeback lands.

## Interface
Parameters:
- XLEN, 32, register width in bits.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- rs1_addr_i  in  5  read port 1 address.
- rs2_addr_i  in  5  read port 2 address.
- rs1_data_o  out  XLEN  read port 1 data, bypassed.
- rs2_data_o  out  XLEN  read port 2 data, bypassed.
- rf_rw_en_i  in  1  write enable from writeback; already qualified for stall/flush.
- rd_addr_i  in  5  write address.
- wb_data_i  in  XLEN  write data.
- issue_valid_i  in  1  an instruction leaves decode this cycle.
- issue_rd_i  in  5  its destination register.
- issue_long_i  in  1  the instruction is long-latency; mark rd pending.
- flush_i  in  1  pipeline flush; clear all pending bits.
- rs1_busy_o  out  1  rs1 has an outstanding long-latency write.
- rs2_busy_o  out  1  rs2 has an outstanding long-latency write.
- rd_busy_o  out  1  issue_rd_i is pending (WAW).

## Operation
- Storage: NREG x XLEN flops plus NREG pending bits; entry 0 is neither stored nor ever pending.
- Write:
  - rf_rw_en_i=1 and rd_addr_i!=0 → regs[rd_addr_i] <= wb_data_i at the clock edge.
  - Writes to x0 are dropped.
- Read, combinational:
  - addr==0 → 0.
  - Else, if rf_rw_en_i and rd_addr_i==addr → wb_data_i (write-through bypass).
  - Else regs[addr].
- Scoreboard set: issue_valid_i & issue_long_i & issue_rd_i!=0 → pending[issue_rd_i] <= 1.
- Scoreboard clear: rf_rw_en_i & rd_addr_i!=0 → pending[rd_addr_i] <= 0.
- Same register set and cleared in one cycle: set wins. The new producer was issued after the retiring one, so the bit stays 1.
- Flush: flush_i=1 clears every pending bit and overrides any same-cycle set. The register write on that cycle still occurs.
- Busy outputs:
  - rsN_busy_o = pending[rsN_addr_i] & ~(rf_rw_en_i & rd_addr_i==rsN_addr_i), i.e. the same-cycle writeback hides busy because the bypass already supplies the data.
  - Always 0 for address 0.
- rd_busy_o uses the same rule against issue_rd_i.
- Decode must not assert issue_valid_i while any consumed busy is 1. The block does not check this.

## Timing
- Read latency: 0 cycles, combinational from address and write port.
- Write visible through the array: the cycle after the write edge. Visible through bypass: the same cycle.
- Pending bit: set visible on busy outputs the cycle after issue. Cleared and masked in the writeback cycle itself.
- Reset (asynchronous assert, synchronous-style release):
  - All registers 0 and all pending bits 0.
  - rs1_data_o/rs2_data_o = 0 while the addresses point to unwritten registers.
  - All busy outputs 0.
- Reset mid-operation: all in-flight pending state is lost; no write is performed on the reset edge.
- Flush and writeback together: data written, pending cleared (both consistent).

## Test plan
- After reset, read all 32 addresses → 0; busy outputs 0.
- Write x5=0xDEADBEEF with rs1_addr_i=5 in the same cycle → rs1_data_o=0xDEADBEEF same cycle. The next cycle without a write still reads 0xDEADBEEF.
- Write x0=0x1234 and issue long to x0 → rs1_data_o for x0 stays 0; no busy is ever raised.
- Issue long rd=7; next cycle rs2_addr_i=7 → rs2_busy_o=1. Three cycles later, writeback x7=0x55 → that cycle rs2_busy_o=0 and rs2_data_o=0x55; pending stays clear afterwards.
- Same cycle: writeback x9 (pending) and issue long rd=9 → next cycle rs1_busy_o=1 for x9.
- Issue long to x3 and x4; assert flush_i → next cycle busy=0 for both. Assert rst_ni low mid-stream with x10=0xFF → x10 reads 0 immediately after reset.
